// File: rtl/pattern_sender.sv
// pattern_sender: plays a stored sequence of 4-bit codes on code_out and
// follows each code with a debouncer-length action_out strobe. Acts as a
// switch-and-button stand-in for driving the pattern checker.
module pattern_sender #(
    parameter int unsigned                 NUM_CODES      = 4,
    parameter logic [NUM_CODES*4-1:0]      PATTERN        = 16'h4A53,
    parameter int unsigned                 NUM_TIMER_BITS = 24,
    parameter int unsigned                 SETUP_CYCLES   = 2**21,
    parameter int unsigned                 PULSE_CYCLES   = 2**22,
    parameter int unsigned                 GAP_CYCLES     = 2**22
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_in,
    output logic [3:0] code_out,
    output logic       action_out,
    output logic       busy_out,
    output logic       done_out
);

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StPulse,
        StGap,
        StDone
    } state_t;

    // Timer reload values; the timer counts down to 0, so a phase of N cycles loads N-1.
    localparam logic [NUM_TIMER_BITS-1:0] SetupLoad = NUM_TIMER_BITS'(SETUP_CYCLES - 1);
    localparam logic [NUM_TIMER_BITS-1:0] PulseLoad = NUM_TIMER_BITS'(PULSE_CYCLES - 1);
    localparam logic [NUM_TIMER_BITS-1:0] GapLoad   = NUM_TIMER_BITS'(GAP_CYCLES - 1);
    localparam logic [2:0]                LastIdx   = 3'(NUM_CODES - 1);

    state_t                    state;
    logic [2:0]                idx;
    logic [NUM_TIMER_BITS-1:0] tmr;
    logic [3:0]                code;

    logic [2:0]                idx_entry;
    logic [3:0]                code_entry;

    // Code to present on the next SETUP entry: code 0 from IDLE, else the following code.
    always_comb begin
        idx_entry  = (state == StIdle) ? 3'd0 : idx + 3'd1;
        code_entry = 4'd0;
        for (int k = 0; k < int'(NUM_CODES); k++) begin
            if (idx_entry == 3'(k)) begin
                code_entry = PATTERN[4*k +: 4];
            end
        end
    end

    // Sequencer: state, code index, phase timer and the registered code.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= StIdle;
            idx   <= 3'd0;
            tmr   <= '0;
            code  <= 4'd0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (start_in) begin
                        state <= StSetup;
                        idx   <= 3'd0;
                        tmr   <= SetupLoad;
                        code  <= code_entry;
                    end
                end
                StSetup: begin
                    if (tmr == '0) begin
                        state <= StPulse;
                        tmr   <= PulseLoad;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                StPulse: begin
                    if (tmr == '0) begin
                        state <= StGap;
                        tmr   <= GapLoad;
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                StGap: begin
                    if (tmr == '0) begin
                        if (idx == LastIdx) begin
                            state <= StDone;
                            code  <= 4'd0;
                        end else begin
                            state <= StSetup;
                            idx   <= idx_entry;
                            tmr   <= SetupLoad;
                            code  <= code_entry;
                        end
                    end else begin
                        tmr <= tmr - 1'b1;
                    end
                end
                StDone: begin
                    state <= StIdle;
                end
                default: begin
                    state <= StIdle;
                    idx   <= 3'd0;
                    tmr   <= '0;
                    code  <= 4'd0;
                end
            endcase
        end
    end

    // Outputs decode directly from registers, so start_in never reaches them combinationally.
    assign code_out   = code;
    assign action_out = (state == StPulse);
    assign busy_out   = (state == StSetup) || (state == StPulse) || (state == StGap);
    assign done_out   = (state == StDone);

endmodule

// File: tb/tb_pattern_sender.sv
// tb_pattern_sender: directed checks of the default-style sequence (S=2, P=3, G=2)
// and of a one-code degenerate instance (S=P=G=1).
module tb_pattern_sender;

    logic       clk = 1'b0;
    logic       reset;
    logic       start_in;
    logic [3:0] code_out;
    logic       action_out;
    logic       busy_out;
    logic       done_out;

    logic       start2;
    logic [3:0] code2;
    logic       action2;
    logic       busy2;
    logic       done2;

    int vectors     = 0;
    int miscompares = 0;
    int pulses;
    logic prev_action;

    always #5 clk = ~clk;

    pattern_sender #(
        .NUM_CODES      (4),
        .PATTERN        (16'h4A53),
        .NUM_TIMER_BITS (4),
        .SETUP_CYCLES   (2),
        .PULSE_CYCLES   (3),
        .GAP_CYCLES     (2)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .start_in   (start_in),
        .code_out   (code_out),
        .action_out (action_out),
        .busy_out   (busy_out),
        .done_out   (done_out)
    );

    pattern_sender #(
        .NUM_CODES      (1),
        .PATTERN        (4'hF),
        .NUM_TIMER_BITS (4),
        .SETUP_CYCLES   (1),
        .PULSE_CYCLES   (1),
        .GAP_CYCLES     (1)
    ) dut_min (
        .clk        (clk),
        .reset      (reset),
        .start_in   (start2),
        .code_out   (code2),
        .action_out (action2),
        .busy_out   (busy2),
        .done_out   (done2)
    );

    // Expected {done, busy, action, code} k cycles after the edge that sampled start.
    function automatic logic [6:0] exp_seq(int k);
        logic [3:0] c;
        int         ph;
        if (k >= 1 && k <= 28) begin
            case ((k - 1) / 7)
                0:       c = 4'h3;
                1:       c = 4'h5;
                2:       c = 4'hA;
                default: c = 4'h4;
            endcase
            ph = (k - 1) % 7;
            return {1'b0, 1'b1, (ph >= 2 && ph <= 4), c};
        end else if (k == 29) begin
            return 7'b100_0000;
        end
        return 7'd0;
    endfunction

    function automatic logic [6:0] exp_min(int k);
        case (k)
            1:       return 7'b010_1111;
            2:       return 7'b011_1111;
            3:       return 7'b010_1111;
            4:       return 7'b100_0000;
            default: return 7'd0;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        assert (got === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic logic [31:0] obs_main();
        return 32'({done_out, busy_out, action_out, code_out});
    endfunction

    function automatic logic [31:0] obs_min();
        return 32'({done2, busy2, action2, code2});
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset    = 1'b1;
        start_in = 1'b0;
        start2   = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset values hold with start low.
        for (int i = 0; i < 20; i++) begin
            chk("reset_idle", obs_main(), 32'd0);
            step();
        end

        // Single run, with start pulses during SETUP of code 1 and during DONE.
        start_in = 1'b1;
        step();
        start_in    = 1'b0;
        pulses      = 0;
        prev_action = 1'b0;
        for (int k = 1; k <= 35; k++) begin
            chk($sformatf("single_c%0d", k), obs_main(), 32'(exp_seq(k)));
            if (action_out === 1'b1 && prev_action === 1'b0) pulses++;
            prev_action = action_out;
            start_in    = (k == 8) || (k == 29);
            step();
        end
        start_in = 1'b0;
        chk("pulse_count", 32'(pulses), 32'd4);

        // Held start: replay begins 31 cycles after the first start edge.
        start_in = 1'b1;
        step();
        for (int k = 1; k <= 41; k++) begin
            chk($sformatf("held_c%0d", k), obs_main(),
                32'((k <= 30) ? exp_seq(k) : exp_seq(k - 30)));
            if (k == 32) start_in = 1'b0;
            if (k == 41) reset = 1'b1;
            step();
        end

        // Reset landed in the second PULSE of the replay.
        reset = 1'b0;
        chk("reset_mid", obs_main(), 32'd0);
        for (int i = 0; i < 35; i++) begin
            step();
            chk("post_reset_idle", obs_main(), 32'd0);
        end

        // A fresh start replays from code 0.
        start_in = 1'b1;
        step();
        start_in = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            chk($sformatf("replay_c%0d", k), obs_main(), 32'(exp_seq(k)));
            step();
        end

        // Degenerate one-code instance.
        chk("min_idle", obs_min(), 32'd0);
        start2 = 1'b1;
        step();
        start2 = 1'b0;
        for (int k = 1; k <= 6; k++) begin
            chk($sformatf("min_c%0d", k), obs_min(), 32'(exp_min(k)));
            step();
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pattern_sender.md
# pattern_sender

Transmit-side counterpart of the pattern checker. On a start strobe it plays a stored sequence of 4-bit codes on `code_out`. For each code it raises an `action_out` strobe long enough to pass the board-level debouncer. It serves as an on-board stimulus source, and in simulation as a bus-functional driver, for the checker path: it drives the checker's code and action inputs exactly as a user would with switches and a button.

## Interface

Parameters:
- `NUM_CODES`, default 4: number of codes in the sequence; valid range 1..8.
- `PATTERN`, default 16'h4A53: packed codes, `NUM_CODES*4` bits wide. Code k sits at bits [4k+3:4k], so code 0 is in the LSBs and is sent first.
- `NUM_TIMER_BITS`, default 24: width of the shared phase timer.
- `SETUP_CYCLES`, default 2**21: cycles `code_out` is stable before `action_out` rises; must be ≥ 1.
- `PULSE_CYCLES`, default 2**22: cycles `action_out` stays high; must be ≥ 1.
- `GAP_CYCLES`, default 2**22: cycles `action_out` stays low after each pulse; must be ≥ 1.
- All `*_CYCLES` values must be < 2**`NUM_TIMER_BITS`.

Ports:
- `clk`, input, 1 bit: single clock.
- `reset`, input, 1 bit: synchronous, active-high.
- `start_in`, input, 1 bit: level sampled each cycle; acted on only in IDLE.
- `code_out`, output, 4 bits: current code; 0 when IDLE.
- `action_out`, output, 1 bit: button-equivalent strobe.
- `busy_out`, output, 1 bit: high in SETUP, PULSE and GAP.
- `done_out`, output, 1 bit: one-cycle pulse after the last GAP.

## Operation

- The FSM has five states: IDLE, SETUP, PULSE, GAP, DONE.
- It uses a code index `idx` (3 bits) and a down-counting timer `tmr` (`NUM_TIMER_BITS` bits).
- **IDLE:** outputs are `code_out`=0, `action_out`=0, `busy_out`=0, `done_out`=0.
  - If `start_in`=1: go to SETUP, set `idx`=0, load `tmr`=`SETUP_CYCLES`-1.
- **SETUP:** `code_out`=`PATTERN[idx]`, `action_out`=0.
  - When `tmr`=0: go to PULSE and load `tmr`=`PULSE_CYCLES`-1.
  - Otherwise decrement `tmr`.
- **PULSE:** `code_out` is unchanged, `action_out`=1.
  - When `tmr`=0: go to GAP and load `tmr`=`GAP_CYCLES`-1.
- **GAP:** `code_out` is unchanged, `action_out`=0.
  - When `tmr`=0 and `idx`=`NUM_CODES`-1: go to DONE.
  - When `tmr`=0 otherwise: increment `idx`, go to SETUP, load `tmr`=`SETUP_CYCLES`-1.
- **DONE:** `done_out`=1, `busy_out`=0, `code_out`=0, `action_out`=0. Go unconditionally to IDLE on the next cycle.
- All outputs are registered (decoded from registered state and registered `code_out`). No combinational path exists from `start_in` to any output.
- `start_in` is ignored in SETUP, PULSE, GAP and DONE. It is not queued. A level still high when the FSM returns to IDLE starts a new sequence immediately (back-to-back replay).
- `code_out` changes only on the entry edge of SETUP and is stable throughout SETUP, PULSE and GAP. `action_out` therefore never rises in the same cycle that `code_out` changes.
- `idx` never exceeds `NUM_CODES`-1; there is no wrap-around.

## Timing

- Reset values: state=IDLE, `idx`=0, `tmr`=0, `code_out`=0, `action_out`=0, `busy_out`=0, `done_out`=0.
- `reset` overrides every other input. Asserting it mid-sequence returns the block to IDLE on the next edge, with `action_out` low from that edge. No `done_out` is issued.
- Phase timing, counting from the edge that samples `start_in`=1 in IDLE as edge N:
  - SETUP of code 0 begins at N+1; `busy_out`=1 and `code_out`=code 0 from N+1.
  - `action_out` rises at N+1+S and is high for exactly P cycles.
  - Each GAP is exactly G cycles.
- Per-code period is S+P+G cycles. `busy_out` is high for exactly `NUM_CODES`*(S+P+G) consecutive cycles.
- `done_out` is high for the single cycle immediately after `busy_out` falls. The earliest restart is then SETUP starting 2 cycles after DONE.
- With default parameters at 100 MHz:
  - pulse and gap are ~42 ms each;
  - both exceed the debouncer's 2**21-cycle (~21 ms) settle time;
  - so each code produces exactly one action pulse at the checker.

## Test plan

Parameters for all scenarios unless noted: `NUM_CODES`=4, `PATTERN`=16'h4A53, S=2, P=3, G=2, `NUM_TIMER_BITS`=4.

- **Reset values:** hold `reset` for 3 cycles, then release with `start_in`=0 → all outputs 0 and stay 0 for 20 cycles.
- **Single run:** 1-cycle `start_in` pulse at edge N → `code_out` sequence 3,5,A,4, each held 7 cycles from N+1.
  - `action_out` high at N+3..N+5, N+10..N+12, N+17..N+19, N+24..N+26.
  - `busy_out` high N+1..N+28; `done_out` high only at N+29.
- **Start while busy:** pulse `start_in` at N+8 and again at N+29 (during DONE) → no effect; exactly 4 `action_out` pulses total.
- **Held start:** hold `start_in`=1 continuously → second sequence's SETUP begins at N+31; `code_out`=3 from N+31.
- **Reset mid-operation:** assert `reset` for 1 cycle during the second PULSE → IDLE next edge; `action_out`, `code_out` and `busy_out` are 0; `done_out` never pulses; a later start replays from code 0.
- **Degenerate case:** `NUM_CODES`=1, `PATTERN`=4'hF, S=P=G=1 → `code_out`=F for 3 cycles, `action_out` high for 1 cycle (the middle one), `done_out` one cycle later.
- **End-to-end integration:** drive the checker top with this block (default timing, `PATTERN` equal to the checker's expected code) → checker reports success (green LED).
